// File: rtl/mem_arbiter.sv
// Byte-serial external RAM sequencer shared by icache refills and LSB loads/stores.
// Optional IO-space store stalling on a full UART buffer: define MEM_IO_STALL_EN.
module mem_arbiter #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    ic_req,
  input  logic [ADDR_W-1:0]       ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_line,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [1:0]              lsb_size,
  input  logic [ADDR_W-1:0]       lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic                    clear
);

  localparam int unsigned CNT_W  = $clog2(LINE_BYTES);
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, IOWAIT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, last_q, last_d, cnt_next;
  logic [1:0]          size_q, size_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LINE_W-1:0]   buf_q, buf_d;
  logic                last_lsb_q, last_lsb_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d, mem_a_next;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic                ic_done_q, ic_done_d, lsb_done_q, lsb_done_d;
  logic [LINE_W-1:0]   ic_line_q, ic_line_d;
  logic [31:0]         lsb_rdata_q, lsb_rdata_d;
  logic                want_ic, want_lsb, pick_lsb;
  logic                stall_grant, stall_next;

  assign mem_a_next = mem_a_q + ADDR_W'(1);
  assign cnt_next   = cnt_q + CNT_W'(1);

`ifdef MEM_IO_STALL_EN
  assign stall_grant = io_buffer_full && (lsb_addr[17:16] == 2'b11);
  assign stall_next  = io_buffer_full && (mem_a_next[17:16] == 2'b11);
`else
  assign stall_grant = 1'b0;
  assign stall_next  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    last_lsb_d  = last_lsb_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    ic_line_d   = ic_line_q;
    lsb_rdata_d = lsb_rdata_q;
    // A requester is ignored while its own done pulse is showing; clear blocks new reads.
    want_ic     = ic_req && !ic_done_q && !clear;
    want_lsb    = lsb_req && !lsb_done_q && !(clear && !lsb_wr);
    pick_lsb    = (want_ic && want_lsb) ? !last_lsb_q : want_lsb;

    case (state_q)
      IDLE: begin
        if (want_ic || want_lsb) begin
          cnt_d      = '0;
          last_lsb_d = pick_lsb;
          if (pick_lsb) begin
            mem_a_d = lsb_addr;
            size_d  = lsb_size;
            wdata_d = lsb_wdata;
            last_d  = (lsb_size == 2'd0) ? CNT_W'(0) :
                      (lsb_size == 2'd1) ? CNT_W'(1) : CNT_W'(3);
            if (lsb_wr) begin
              mem_dout_d = lsb_wdata[7:0];
              state_d    = stall_grant ? IOWAIT : STORE;
              mem_wr_d   = !stall_grant;
            end else begin
              state_d  = LOAD;
              mem_wr_d = 1'b0;
            end
          end else begin
            mem_a_d  = ic_addr;
            last_d   = CNT_W'(LINE_BYTES - 1);
            state_d  = IFETCH;
            mem_wr_d = 1'b0;
          end
        end
      end
      IFETCH, LOAD: begin
        if (clear) begin
          state_d  = IDLE;
          mem_wr_d = 1'b0;
        end else begin
          // mem_din now holds the byte addressed on the previous cycle.
          buf_d[{cnt_q, 3'b000} +: 8] = mem_din;
          if (cnt_q == last_q) begin
            state_d = IDLE;
            if (state_q == IFETCH) begin
              ic_done_d = 1'b1;
              ic_line_d = buf_d;
            end else begin
              lsb_done_d = 1'b1;
              case (size_q)
                2'd0:    lsb_rdata_d = {24'b0, buf_d[7:0]};
                2'd1:    lsb_rdata_d = {16'b0, buf_d[15:0]};
                default: lsb_rdata_d = buf_d[31:0];
              endcase
            end
          end else begin
            cnt_d   = cnt_next;
            mem_a_d = mem_a_next;
          end
        end
      end
      STORE: begin
        if (cnt_q == last_q) begin
          state_d    = IDLE;
          mem_wr_d   = 1'b0;
          lsb_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_next;
          mem_a_d    = mem_a_next;
          mem_dout_d = wdata_q[{cnt_next[1:0], 3'b000} +: 8];
          state_d    = stall_next ? IOWAIT : STORE;
          mem_wr_d   = !stall_next;
        end
      end
      IOWAIT: begin
        if (!io_buffer_full) begin
          state_d  = STORE;
          mem_wr_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      last_lsb_q  <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      ic_line_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      last_lsb_q  <= last_lsb_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      ic_line_q   <= ic_line_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign ic_done   = ic_done_q;
  assign ic_line   = ic_line_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LSB vector table plus refill, arbitration, clear, rdy and reset sequences.
module tb_mem_arbiter;
  localparam int LB = 16;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst, rdy, mem_wr, io_buffer_full, ic_req, ic_done;
  logic            lsb_req, lsb_wr, lsb_done, clear;
  logic [7:0]      mem_din, mem_dout;
  logic [AW-1:0]   mem_a, ic_addr, lsb_addr;
  logic [LB*8-1:0] ic_line;
  logic [1:0]      lsb_size;
  logic [31:0]     lsb_wdata, lsb_rdata;

  logic [7:0] ram [0:4095];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_line(ic_line),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .clear(clear)
  );

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[11:0]];
  always @(posedge clk) if (mem_wr) ram[mem_a[11:0]] <= mem_dout;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          n;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic lsb_run(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output int lat,
                         output bit seq_ok);
    @(negedge clk);
    lsb_req = 1'b1; lsb_wr = wr; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata;
    lat = -1; seq_ok = 1'b1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (lsb_done) begin
        lat = c; rd = lsb_rdata; lsb_req = 1'b0;
        if (mem_wr) seq_ok = 1'b0;
        break;
      end
      if (mem_a !== addr + 32'(c) || mem_wr !== wr) seq_ok = 1'b0;
      if (wr && mem_dout !== 8'(wdata >> (8 * c))) seq_ok = 1'b0;
    end
    lsb_req = 1'b0;
    @(posedge clk); #1;
    if (lat >= 0) chk("lsb_done_pulse", lsb_done, 0);
  endtask

  task automatic ic_run(input logic [31:0] a, output logic [127:0] line, output int lat,
                        output bit wr_seen);
    @(negedge clk);
    ic_req = 1'b1; ic_addr = a; lat = -1; wr_seen = 1'b0; line = '0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (mem_wr) wr_seen = 1'b1;
      if (ic_done) begin lat = c; line = ic_line; ic_req = 1'b0; break; end
    end
    ic_req = 1'b0;
    @(posedge clk); #1;
    if (lat >= 0) chk("ic_done_pulse", ic_done, 0);
  endtask

  // first: 1 = LSB finished first, 2 = icache first; ic_at = sample index of ic_done
  task automatic both_run(output int first, output int ic_at);
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h40;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h100;
    first = 0; ic_at = -1;
    for (int c = 0; c < 60 && (ic_req || lsb_req); c++) begin
      @(posedge clk); #1;
      if (lsb_done && lsb_req) begin if (first == 0) first = 1; lsb_req = 1'b0; end
      if (ic_done && ic_req) begin if (first == 0) first = 2; ic_req = 1'b0; ic_at = c; end
    end
    ic_req = 1'b0; lsb_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rd;
    logic [127:0] line, exp_line;
    int           lat, first, ic_at;
    bit           ok, wr_seen, done_seen;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h5A;
    for (int i = 0; i < 16; i++) ram[32'h40 + i] = 8'(i);
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'hFFE] = 8'hAA; ram[12'hFFF] = 8'hBB; ram[12'h000] = 8'hCC; ram[12'h001] = 8'hDD;

    vecs[0]  = '{1'b0, 2'd2, 32'h100,      32'h0,        32'h44332211, 4};
    vecs[1]  = '{1'b0, 2'd0, 32'h101,      32'h0,        32'h00000022, 1};
    vecs[2]  = '{1'b0, 2'd1, 32'h102,      32'h0,        32'h00004433, 2};
    vecs[3]  = '{1'b0, 2'd3, 32'h100,      32'h0,        32'h44332211, 4};
    vecs[4]  = '{1'b1, 2'd0, 32'h200,      32'hDEADBEEF, 32'h0,        1};
    vecs[5]  = '{1'b0, 2'd1, 32'h200,      32'h0,        32'h00005AEF, 2};
    vecs[6]  = '{1'b1, 2'd2, 32'h203,      32'h01234567, 32'h0,        4};
    vecs[7]  = '{1'b0, 2'd2, 32'h203,      32'h0,        32'h01234567, 4};
    vecs[8]  = '{1'b1, 2'd1, 32'h300,      32'h0000CAFE, 32'h0,        2};
    vecs[9]  = '{1'b0, 2'd0, 32'h301,      32'h0,        32'h000000CA, 1};
    vecs[10] = '{1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        32'hDDCCBBAA, 4};
    vecs[11] = '{1'b0, 2'd1, 32'hFFFFFFFF, 32'h0,        32'h0000CCBB, 2};

    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
    ic_req = 1'b0; ic_addr = '0; lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = '0;
    lsb_addr = '0; lsb_wdata = '0;
    #2 rst = 1'b1;
    #2;
    chk("reset_outs", {ic_done, lsb_done, mem_wr, mem_dout, mem_a, lsb_rdata}, '0);
    chk("reset_line", ic_line, '0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      lsb_run(vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata, rd, lat, ok);
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].n));
      chk($sformatf("vec%0d_addr_seq", v), 128'(ok), 128'(1));
      if (!vecs[v].wr) chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
    end
    chk("store1_byte0", ram[12'h200], 8'hEF);
    chk("store1_byte1_untouched", ram[12'h201], 8'h5A);

    // icache refill of line 0x40
    for (int i = 0; i < 16; i++) exp_line[i*8 +: 8] = 8'(i);
    ic_run(32'h40, line, lat, wr_seen);
    chk("ic_latency", 128'(lat), 128'(16));
    chk("ic_line", line, exp_line);
    chk("ic_no_write", 128'(wr_seen), 128'(0));

    // last grant was IC: LSB wins, icache granted the cycle after lsb_done
    both_run(first, ic_at);
    chk("arb_first_lsb", 128'(first), 128'(1));
    chk("arb_ic_after_lsb", 128'(ic_at), 128'(18));
    lsb_run(1'b0, 2'd0, 32'h100, 32'h0, rd, lat, ok);
    chk("arb_lone_lsb", rd, 32'h11);
    both_run(first, ic_at);
    chk("arb_first_ic", 128'(first), 128'(2));
    chk("arb_ic_first_at", 128'(ic_at), 128'(16));

    // clear while byte 5 of a refill is being addressed
    @(negedge clk); ic_req = 1'b1; ic_addr = 32'h40; done_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ic_done) done_seen = 1'b1;
      if (c == 5) begin chk("clr_ic_addr", mem_a, 32'h45); clear = 1'b1; ic_req = 1'b0; end
      else if (c == 6) begin clear = 1'b0; chk("clr_ic_wr", mem_wr, 0); end
    end
    chk("clr_ic_no_done", 128'(done_seen), 128'(0));
    lsb_run(1'b0, 2'd1, 32'h100, 32'h0, rd, lat, ok);
    chk("clr_ic_then_load_lat", 128'(lat), 128'(2));

    // clear during a store has no effect
    @(negedge clk); lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2;
    lsb_addr = 32'h400; lsb_wdata = 32'h11223344; lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (lsb_done) begin lat = c; break; end
      clear = (c == 1);
    end
    clear = 1'b0; lsb_req = 1'b0;
    @(posedge clk); #1;
    chk("clr_store_lat", 128'(lat), 128'(4));
    chk("clr_store_mem", {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]}, 32'h11223344);

    // clear in IDLE with a pending load delays the grant by one cycle
    @(negedge clk); lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h100;
    clear = 1'b1; lat = -1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      clear = 1'b0;
      if (lsb_done) begin lat = c; rd = lsb_rdata; break; end
    end
    lsb_req = 1'b0;
    @(posedge clk); #1;
    chk("clr_idle_lat", 128'(lat), 128'(2));
    chk("clr_idle_rdata", rd, 32'h11);

    // rdy low for three edges mid-load
    @(negedge clk); lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h100;
    lat = -1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (lsb_done) begin lat = c; rd = lsb_rdata; break; end
      if (c == 1) rdy = 1'b0;
      if (c == 4) begin chk("rdy_frozen_addr", mem_a, 32'h101); rdy = 1'b1; end
    end
    lsb_req = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk("rdy_load_lat", 128'(lat), 128'(7));
    chk("rdy_load_rdata", rd, 32'h44332211);

    // done pulse held while rdy is low
    @(negedge clk); lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h102;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (lsb_done) begin lsb_req = 1'b0; rdy = 1'b0; break; end
    end
    lsb_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rdy_done_held", {lsb_done, lsb_rdata}, {1'b1, 32'h33});
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("rdy_done_released", lsb_done, 0);

    // asynchronous reset in the middle of a store
    @(negedge clk); lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2;
    lsb_addr = 32'h500; lsb_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    chk("rst_store_started", mem_wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", {ic_done, lsb_done, mem_wr, mem_dout, mem_a, lsb_rdata}, '0);
    lsb_req = 1'b0;
    @(negedge clk); rst = 1'b0;

    // IO-space store with the UART buffer full for three cycles
    io_buffer_full = 1'b1;
`ifdef MEM_IO_STALL_EN
    @(negedge clk); lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0;
    lsb_addr = 32'h30000; lsb_wdata = 32'h77; lat = -1; wr_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (lsb_done) begin lat = c; break; end
      if (c < 3 && mem_wr) wr_seen = 1'b1;
      if (c == 2) io_buffer_full = 1'b0;
    end
    lsb_req = 1'b0;
    @(posedge clk); #1;
    chk("io_no_write_while_full", 128'(wr_seen), 128'(0));
    chk("io_stall_lat", 128'(lat), 128'(4));
`else
    lsb_run(1'b1, 2'd0, 32'h30000, 32'h77, rd, lat, ok);
    chk("io_nostall_lat", 128'(lat), 128'(1));
    chk("io_nostall_seq", 128'(ok), 128'(1));
`endif
    io_buffer_full = 1'b0;
    chk("io_store_mem", ram[12'h000], 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide external RAM port and shares it between two requesters: the instruction cache (line refill on miss) and the load/store buffer (1/2/4-byte loads and stores).
- Sits between icache/LSB and the top-level memory pins.
- Serialises multi-byte transfers, arbitrates fairly, and aborts speculative reads on a ROB clear.

Parameters:
- LINE_BYTES, 16, bytes per icache refill; power of 2, range 4..64.
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- mem_din  in  8  RAM read data, valid one cycle after address issue
- mem_dout  out  8  RAM write data
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART buffer full
- ic_req  in  1  icache refill request; held until ic_done
- ic_addr  in  ADDR_W  line-aligned refill address
- ic_done  out  1  one-cycle pulse: ic_line valid
- ic_line  out  LINE_BYTES*8  refill data, byte 0 in bits [7:0]
- lsb_req  in  1  LSB request; held until lsb_done
- lsb_wr  in  1  1 = store
- lsb_size  in  2  0 = 1B, 1 = 2B, 2 = 4B; 3 is illegal and treated as 4B
- lsb_addr  in  ADDR_W  byte address
- lsb_wdata  in  32  store data, little-endian
- lsb_done  out  1  one-cycle pulse: access complete
- lsb_rdata  out  32  load data, zero-extended; upper bytes 0
- clear  in  1  ROB mispredict flush

Behaviour:
- Reset (async): state IDLE, mem_a = 0, mem_wr = 0, mem_dout = 0, ic_done = 0, lsb_done = 0, ic_line = 0, lsb_rdata = 0, last_grant = IC.
- States: IDLE, IFETCH, LOAD, STORE, plus an optional IOWAIT.
- IDLE arbitration:
  - Only one requester: grant it.
  - Both requesting: grant the one opposite last_grant (alternate).
  - Grant latches address, size and data. mem_a = first byte address in the same cycle. mem_wr = 1 only for a store.
- Reads (IFETCH/LOAD), N bytes:
  - Cycle k (0..N-1) drives mem_a = base + k.
  - Byte k is captured from mem_din in cycle k+1.
  - Done pulse in cycle N; return to IDLE the same cycle.
  - Latency from grant to done = N cycles; the next grant is possible the cycle after done.
  - mem_a beyond the last byte is don't-care, but mem_wr must be 0.
- Stores, N bytes:
  - Cycle k drives mem_a = base + k, mem_dout = wdata byte k, mem_wr = 1.
  - lsb_done pulses in cycle N with mem_wr = 0.
- Done pulses last exactly one cycle. Requesters deassert req in the done cycle; the arbiter ignores req during the done cycle.
- Address arithmetic wraps modulo 2^ADDR_W. No alignment is required.
- clear:
  - IFETCH or LOAD in progress: abort immediately, no done pulse, back to IDLE next cycle, mem_wr = 0.
  - STORE in progress: unaffected. Stores are committed and always complete.
  - clear in IDLE with a pending load/ifetch request: no grant that cycle.
- rdy = 0: freeze everything, including the byte counter. Done pulses are not lost: a pulse coinciding with rdy low is re-presented when rdy returns.
- last_grant updates only on grant, not on abort.

Optional Feature:
- Macro: MEM_IO_STALL_EN.
- Defined:
  - A store whose address[17:16] == 2'b11 (IO space, 0x30000+) while io_buffer_full = 1 enters IOWAIT.
  - In IOWAIT, mem_wr = 0 and the arbiter waits until io_buffer_full = 0, then performs the store.
  - IOWAIT is also checked before each store byte.
- Not defined: io_buffer_full is ignored; IO stores proceed without stalling.

Test Plan:
- LSB-only load: lsb_req, size 2, addr 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles; lsb_done 4 cycles after grant; lsb_rdata = 0x44332211.
- Icache refill: ic_addr 0x40, LINE_BYTES 16, RAM[i] = i -> ic_done after 16 cycles; ic_line = 0x0F0E..0100; mem_wr never 1.
- Simultaneous requests: ic_req and lsb_req asserted together, last_grant = IC -> LSB served first, then icache; repeat -> order alternates.
- Store size 1: addr 0x200, wdata 0xDEADBEEF -> single write cycle, mem_dout = 0xEF, mem_wr = 1; lsb_done next cycle; RAM[0x201] unchanged.
- Clear mid-refill: clear at byte 5 of an icache fill -> no ic_done, mem_wr = 0, IDLE next cycle. Clear during a store -> store completes and lsb_done pulses.
- Reset mid-store, plus MEM_IO_STALL_EN: rst during STORE -> all outputs 0 asynchronously. Store to 0x30000 with io_buffer_full = 1 for 3 cycles -> no mem_wr until full drops, then lsb_done.
